// File: rtl/fu_issue_sequencer_pkg.sv
// Shared constants, opcode encodings and sequencer state type for the single-FU
// burst issue sequencer.
package fu_issue_sequencer_pkg;

    localparam int DATA_W      = 16;
    localparam int INST_W      = 24;
    localparam int IMEM_AW     = 4;
    localparam int RF_AW       = 6;
    localparam int PIPE_LAT    = 4;
    localparam int OFIFO_DEPTH = 8;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_MUL  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_SUBI = 6'h05;
    localparam logic [5:0] OP_MULI = 6'h06;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    // Instruction layout: opcode[23:18] dst[17:12] src1[11:6] src2/imm[5:0]
    function automatic logic [INST_W-1:0] make_inst(input logic [5:0] op,
                                                    input logic [5:0] dst,
                                                    input logic [5:0] src1,
                                                    input logic [5:0] src2);
        return {op, dst, src1, src2};
    endfunction

endpackage

// File: rtl/fu_seq_fifo.sv
// Synchronous result FIFO with occupancy count; pop on empty is ignored and
// overflow is guarded by the sequencer's issue credit.
module fu_seq_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!i_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(i_push && !w_pop && r_count == FULL_CNT));
    end

endmodule

// File: rtl/fu_issue_sequencer.sv
// Burst scheduler: loads samples into the FU register file, issues a programmed
// instruction list under output-FIFO credit, and collects fixed-latency results.
module fu_issue_sequencer #(
    parameter int DATA_W      = fu_issue_sequencer_pkg::DATA_W,
    parameter int INST_W      = fu_issue_sequencer_pkg::INST_W,
    parameter int IMEM_AW     = fu_issue_sequencer_pkg::IMEM_AW,
    parameter int RF_AW       = fu_issue_sequencer_pkg::RF_AW,
    parameter int PIPE_LAT    = fu_issue_sequencer_pkg::PIPE_LAT,
    parameter int OFIFO_DEPTH = fu_issue_sequencer_pkg::OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_prog_we,
    input  logic [IMEM_AW-1:0] i_prog_addr,
    input  logic [INST_W-1:0]  i_prog_data,
    output logic               o_prog_err,
    input  logic [RF_AW:0]     i_cfg_nsamp,
    input  logic [IMEM_AW:0]   i_cfg_ninst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    input  logic [DATA_W-1:0]  i_s_data,
    output logic               o_rf_we,
    output logic [RF_AW-1:0]   o_rf_waddr,
    output logic [DATA_W-1:0]  o_rf_wdata,
    output logic [INST_W-1:0]  o_inst,
    output logic               o_inst_v,
    input  logic [DATA_W-1:0]  i_fu_result,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic [DATA_W-1:0]  o_m_data
);

    import fu_issue_sequencer_pkg::*;

    localparam int CNT_W = $clog2(OFIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(PIPE_LAT + 2);
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    seq_state_e          r_state, w_next;
    logic [INST_W-1:0]   r_imem [2**IMEM_AW];
    logic [RF_AW:0]      r_nsamp, r_scnt;
    logic [IMEM_AW:0]    r_ninst, r_pc;
    logic [INST_W-1:0]   r_inst;
    logic                r_inst_v, r_done, r_prog_err;
    logic [PIPE_LAT-1:0] r_lat;

    logic                w_busy, w_s_ready, w_start, w_accept, w_issue;
    logic                w_last_sample, w_last_inst, w_credit_ok, w_drained;
    logic [OUT_W-1:0]    w_outstanding;
    logic [SUM_W-1:0]    w_used;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_empty;
    logic [DATA_W-1:0]   w_fifo_head;

    fu_seq_fifo #(.DATA_W(DATA_W), .DEPTH(OFIFO_DEPTH)) u_ofifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_lat[PIPE_LAT-1]),
        .i_wdata (i_fu_result),
        .i_pop   (i_m_ready),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Issued-but-not-yet-captured results: the inst_v register plus the latency taps.
    always_comb begin
        w_outstanding = OUT_W'(r_inst_v);
        for (int i = 0; i < PIPE_LAT; i++) w_outstanding = w_outstanding + OUT_W'(r_lat[i]);
    end

    assign w_used        = SUM_W'(w_fifo_count) + SUM_W'(w_outstanding);
    assign w_credit_ok   = (w_used < SUM_W'(OFIFO_DEPTH));
    assign w_drained     = (w_outstanding == '0) && w_fifo_empty;
    assign w_last_sample = ((r_scnt + (RF_AW+1)'(1)) == r_nsamp);
    assign w_last_inst   = ((r_pc + (IMEM_AW+1)'(1)) == r_ninst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: combinational processes use blocking assignments with a default first.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (i_start) begin
                if (i_cfg_nsamp != '0)      w_next = ST_LOAD;
                else if (i_cfg_ninst != '0) w_next = ST_ISSUE;
                else                        w_next = ST_DRAIN;
            end
            ST_LOAD: if (w_accept && w_last_sample)
                w_next = (r_ninst != '0) ? ST_ISSUE : ST_DRAIN;
            ST_ISSUE: if (w_issue && w_last_inst) w_next = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        w_s_ready = (r_state == ST_LOAD);
        w_start   = (r_state == ST_IDLE) && i_start;
        w_accept  = w_s_ready && i_s_valid;
        w_issue   = (r_state == ST_ISSUE) && w_credit_ok;
    end

    always_ff @(posedge clk) begin
        if (i_prog_we && !w_busy) r_imem[i_prog_addr] <= i_prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nsamp    <= '0;
            r_ninst    <= '0;
            r_scnt     <= '0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_inst_v   <= 1'b0;
            r_lat      <= '0;
            r_done     <= 1'b0;
            r_prog_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_nsamp <= i_cfg_nsamp;
                r_ninst <= i_cfg_ninst;
                r_scnt  <= '0;
                r_pc    <= '0;
            end
            if (w_accept) r_scnt <= r_scnt + (RF_AW+1)'(1);
            if (w_issue) begin
                r_pc   <= r_pc + (IMEM_AW+1)'(1);
                r_inst <= r_imem[r_pc[IMEM_AW-1:0]];
            end
            r_inst_v <= w_issue;
            r_lat    <= {r_lat[PIPE_LAT-2:0], r_inst_v};
            r_done   <= (r_state == ST_DRAIN) && w_drained;
            if (w_start)                  r_prog_err <= 1'b0;
            else if (i_prog_we && w_busy) r_prog_err <= 1'b1;
        end
    end

    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_prog_err = r_prog_err;
    assign o_s_ready  = w_s_ready;
    assign o_rf_we    = w_accept;
    assign o_rf_waddr = w_accept ? r_scnt[RF_AW-1:0] : '0;
    assign o_rf_wdata = w_accept ? i_s_data : '0;
    assign o_inst     = r_inst;
    assign o_inst_v   = r_inst_v;
    assign o_m_valid  = !w_fifo_empty;
    assign o_m_data   = w_fifo_empty ? '0 : w_fifo_head;

endmodule

// File: tb/tb_fu_issue_sequencer.sv
// Directed bench for fu_issue_sequencer: FU modelled as a 4-stage delay of
// inst_o[15:0]+0x1000; results and issues logged at the falling edge.
module tb_fu_issue_sequencer;

    import fu_issue_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_prog_we = 1'b0;
    logic [3:0]  i_prog_addr = '0;
    logic [23:0] i_prog_data = '0;
    logic        o_prog_err;
    logic [6:0]  i_cfg_nsamp = '0;
    logic [4:0]  i_cfg_ninst = '0;
    logic        i_start = 1'b0;
    logic        o_busy, o_done;
    logic        i_s_valid = 1'b0;
    logic        o_s_ready;
    logic [15:0] i_s_data = '0;
    logic        o_rf_we;
    logic [5:0]  o_rf_waddr;
    logic [15:0] o_rf_wdata;
    logic [23:0] o_inst;
    logic        o_inst_v;
    logic [15:0] i_fu_result;
    logic        o_m_valid;
    logic        i_m_ready = 1'b0;
    logic [15:0] o_m_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int d0;
    logic [23:0] exp_imem [16];
    logic [15:0] fu_pipe [4];
    logic [5:0]  rf_addr_q [$];
    logic [15:0] rf_data_q [$];
    logic [23:0] inst_q [$];
    int          inst_cyc_q [$];
    logic [15:0] res_q [$];
    int          res_cyc_q [$];

    fu_issue_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
        .o_prog_err(o_prog_err), .i_cfg_nsamp(i_cfg_nsamp), .i_cfg_ninst(i_cfg_ninst),
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_inst(o_inst), .o_inst_v(o_inst_v), .i_fu_result(i_fu_result),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fu_model(input logic [23:0] w);
        return w[15:0] + 16'h1000;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fu_pipe[0] <= o_inst_v ? fu_model(o_inst) : 16'hDEAD;
        for (int i = 1; i < 4; i++) fu_pipe[i] <= fu_pipe[i-1];
    end
    assign i_fu_result = fu_pipe[3];

    always @(negedge clk) begin
        if (o_rf_we) begin rf_addr_q.push_back(o_rf_waddr); rf_data_q.push_back(o_rf_wdata); end
        if (o_inst_v) begin inst_q.push_back(o_inst); inst_cyc_q.push_back(cyc); end
        if (o_m_valid && i_m_ready) begin res_q.push_back(o_m_data); res_cyc_q.push_back(cyc); end
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        rf_addr_q.delete(); rf_data_q.delete(); inst_q.delete();
        inst_cyc_q.delete(); res_q.delete(); res_cyc_q.delete();
    endtask

    task automatic start_burst(input logic [6:0] ns, input logic [4:0] ni);
        i_cfg_nsamp = ns; i_cfg_ninst = ni; i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic feed(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            i_s_valid = 1'b1; i_s_data = base + 16'(i);
            @(negedge clk);
            while (!o_s_ready && k < 50) begin @(negedge clk); k++; end
            check("s_ready_wait", 32'(k < 50), 32'd1);
            @(posedge clk); #1;
        end
        i_s_valid = 1'b0; i_s_data = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        int d;
        k = 0; d = done_cnt;
        while (done_cnt == d && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(done_cnt != d), 32'd1);
        tick();
    endtask

    function automatic logic [31:0] q_inst(input int k);
        return (inst_q.size() > k) ? 32'(inst_q[k]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q_res(input int k);
        return (res_q.size() > k) ? 32'(res_q[k]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++)
            exp_imem[k] = make_inst(OP_ADD + 6'(k % 6), 6'(k), 6'(k + 1), 6'(k + 3));

        // Reset state
        repeat (2) tick();
        check("rst_flags", 32'({o_busy, o_done, o_s_ready, o_rf_we, o_inst_v, o_m_valid, o_prog_err}), 32'd0);
        check("rst_inst", 32'(o_inst), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            i_prog_we = 1'b1; i_prog_addr = 4'(k); i_prog_data = exp_imem[k];
            tick();
        end
        i_prog_we = 1'b0;
        check("prog_err_idle", 32'(o_prog_err), 32'd0);

        // 1: basic burst, 4 samples, 4 instructions, no back-pressure
        clear_logs(); i_m_ready = 1'b1; d0 = done_cnt;
        start_burst(7'd4, 5'd4);
        check("t1_busy", 32'(o_busy), 32'd1);
        feed(4, 16'd5);
        wait_done("t1_done_seen", 200);
        repeat (5) tick();
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_rf_n", 32'(rf_addr_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t1_rf_addr", (rf_addr_q.size() > k) ? 32'(rf_addr_q[k]) : 32'hFFFF, 32'(k));
            check("t1_rf_data", (rf_data_q.size() > k) ? 32'(rf_data_q[k]) : 32'hFFFF, 32'(5 + k));
        end
        check("t1_inst_n", 32'(inst_q.size()), 32'd4);
        check("t1_res_n", 32'(res_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t1_inst", q_inst(k), 32'(exp_imem[k]));
            check("t1_res", q_res(k), 32'(fu_model(exp_imem[k])));
            if (k < res_cyc_q.size() && k < inst_cyc_q.size())
                check("t1_latency", 32'(res_cyc_q[k] - inst_cyc_q[k]), 32'd5);
        end
        check("t1_idle", 32'({o_busy, o_m_valid}), 32'd0);

        // 2: output stalled for the whole burst, 16 instructions
        clear_logs(); i_m_ready = 1'b0;
        start_burst(7'd2, 5'd16);
        feed(2, 16'd100);
        repeat (40) tick();
        check("t2_stall_issues", 32'(inst_q.size()), 32'd8);
        check("t2_stall_busy", 32'({o_busy, o_m_valid}), 32'd3);
        check("t2_no_pop", 32'(res_q.size()), 32'd0);
        i_m_ready = 1'b1;
        wait_done("t2_done_seen", 400);
        check("t2_res_n", 32'(res_q.size()), 32'd16);
        for (int k = 0; k < 16; k++)
            check("t2_res_order", q_res(k), 32'(fu_model(exp_imem[k])));

        // 3: empty burst
        clear_logs(); d0 = done_cnt;
        start_burst(7'd0, 5'd0);
        check("t3_busy_1cyc", 32'({o_busy, o_done}), 32'b10);
        tick();
        check("t3_done", 32'({o_busy, o_done}), 32'b01);
        tick();
        check("t3_done_pulse", 32'({o_busy, o_done}), 32'b00);
        check("t3_no_activity", 32'(rf_addr_q.size() + inst_q.size()), 32'd0);
        check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 4: IMEM write attempted while issuing
        clear_logs();
        start_burst(7'd0, 5'd16);
        i_prog_we = 1'b1; i_prog_addr = 4'd2; i_prog_data = 24'hFFFFFF;
        tick();
        i_prog_we = 1'b0;
        check("t4_prog_err_set", 32'({o_busy, o_prog_err}), 32'b11);
        wait_done("t4_done_seen", 200);
        check("t4_prog_err_sticky", 32'(o_prog_err), 32'd1);
        clear_logs();
        start_burst(7'd0, 5'd3);
        check("t4_prog_err_clr", 32'(o_prog_err), 32'd0);
        wait_done("t4b_done_seen", 200);
        check("t4_imem_kept", q_inst(2), 32'(exp_imem[2]));
        check("t4_res_kept", q_res(2), 32'(fu_model(exp_imem[2])));

        // 5: reset in ISSUE with 3 results outstanding
        clear_logs(); i_m_ready = 1'b1;
        start_burst(7'd0, 5'd16);
        repeat (3) tick();
        check("t5_issuing", 32'(o_inst_v), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_flags", 32'({o_busy, o_done, o_s_ready, o_rf_we, o_inst_v, o_m_valid, o_prog_err}), 32'd0);
        check("t5_async_inst", 32'({o_inst, o_m_data}), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_logs(); d0 = done_cnt;
        repeat (12) tick();
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_fifo_empty", 32'({o_m_valid, 1'b0}) + 32'(res_q.size()), 32'd0);
        start_burst(7'd2, 5'd3);
        feed(2, 16'd40);
        wait_done("t5_fresh_done", 200);
        check("t5_fresh_res_n", 32'(res_q.size()), 32'd3);
        check("t5_fresh_res2", q_res(2), 32'(fu_model(exp_imem[2])));
        check("t5_fresh_rf", (rf_data_q.size() > 1) ? 32'(rf_data_q[1]) : 32'hFFFF, 32'd41);

        // 6: start pulsed during LOAD must be ignored
        clear_logs();
        start_burst(7'd3, 5'd1);
        feed(1, 16'd200);
        start_burst(7'd1, 5'd5);
        check("t6_still_load", 32'({o_busy, o_s_ready}), 32'b11);
        feed(2, 16'd201);
        wait_done("t6_done_seen", 200);
        check("t6_rf_n", 32'(rf_addr_q.size()), 32'd3);
        check("t6_rf_addr2", (rf_addr_q.size() > 2) ? 32'(rf_addr_q[2]) : 32'hFF, 32'd2);
        check("t6_rf_data2", (rf_data_q.size() > 2) ? 32'(rf_data_q[2]) : 32'hFFFF, 32'd202);
        check("t6_inst_n", 32'(inst_q.size()), 32'd1);
        check("t6_inst0", q_inst(0), 32'(exp_imem[0]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
